// File: rtl/spart_bus_fifo_if_if.sv
// Bundles the SPART-side handshakes and CPU control strobes of spart_bus_fifo_if.
// irq exists only when SPART_BUS_IRQ_EN is defined.
interface spart_bus_fifo_if_if;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] divisor;
    logic        div_load;
`ifdef SPART_BUS_IRQ_EN
    logic        irq;
`endif

    modport slave (
        input  iocs, iorw, ioaddr, tx_ready, rx_data, rx_valid,
`ifdef SPART_BUS_IRQ_EN
        output irq,
`endif
        output tx_data, tx_valid, divisor, div_load
    );

    modport master (
        output iocs, iorw, ioaddr, tx_ready, rx_data, rx_valid,
`ifdef SPART_BUS_IRQ_EN
        input  irq,
`endif
        input  tx_data, tx_valid, divisor, div_load
    );
endinterface

// File: rtl/spart_bus_fifo_if.sv
// Clocked SPART CPU bus interface: TX/RX FIFOs, divisor registers, sticky overflow status.
// Optional registered interrupt output enabled by defining SPART_BUS_IRQ_EN.
module spart_bus_fifo_if #(
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'h0145
) (
    input  logic               clk,
    input  logic               rst_n,
    spart_bus_fifo_if_if.slave bus,
    inout  wire  [7:0]         databus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic [15:0]      div_q;
    logic             div_load_q;

    logic rd_acc, wr_acc;
    logic data_rd, status_rd, data_wr, lo_wr, hi_wr;
    logic tx_full, tx_pop, tx_push, tx_ovf_set;
    logic rx_full, rx_pop, rx_push, rx_ovf_set;
    logic [7:0] tx_free;
    logic [3:0] tx_free_sat;
    logic [7:0] status;
    logic [7:0] rd_data;

    assign rd_acc    = bus.iocs & bus.iorw;
    assign wr_acc    = bus.iocs & ~bus.iorw;
    assign data_rd   = rd_acc & (bus.ioaddr == 2'd0);
    assign status_rd = rd_acc & (bus.ioaddr == 2'd1);
    assign data_wr   = wr_acc & (bus.ioaddr == 2'd0);
    assign lo_wr     = wr_acc & (bus.ioaddr == 2'd2);
    assign hi_wr     = wr_acc & (bus.ioaddr == 2'd3);

    // A full FIFO still accepts a push when the same edge frees a slot.
    assign tx_full    = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign tx_pop     = (tx_cnt_q != '0) & bus.tx_ready;
    assign tx_push    = data_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = data_wr & tx_full & ~tx_pop;

    assign rx_full    = (rx_cnt_q == RX_CW'(RX_DEPTH));
    assign rx_pop     = data_rd & (rx_cnt_q != '0);
    assign rx_push    = bus.rx_valid & (~rx_full | rx_pop);
    assign rx_ovf_set = bus.rx_valid & rx_full & ~rx_pop;

    assign tx_free     = 8'(TX_DEPTH) - 8'(tx_cnt_q);
    assign tx_free_sat = (tx_free > 8'd15) ? 4'hF : tx_free[3:0];
    assign status      = {tx_free_sat, tx_ovf_q, rx_ovf_q, ~tx_full, (rx_cnt_q != '0)};

    always_comb begin
        tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
        // A fresh overflow in the clearing STATUS read keeps the bit set.
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~status_rd);
        rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~status_rd);
    end

    always_comb begin
        rd_data = 8'h00;
        case (bus.ioaddr)
            2'd0:    rd_data = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : 8'h00;
            2'd1:    rd_data = status;
            2'd2:    rd_data = div_q[7:0];
            default: rd_data = div_q[15:8];
        endcase
    end

    assign databus = rd_acc ? rd_data : 8'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
            for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            div_q      <= DIV_RESET;
            div_load_q <= 1'b0;
        end else begin
            if (tx_push) tx_mem_q[tx_wr_q] <= databus;
            if (rx_push) rx_mem_q[rx_wr_q] <= bus.rx_data;
            tx_wr_q    <= tx_wr_q + TX_AW'(tx_push);
            tx_rd_q    <= tx_rd_q + TX_AW'(tx_pop);
            tx_cnt_q   <= tx_cnt_d;
            rx_wr_q    <= rx_wr_q + RX_AW'(rx_push);
            rx_rd_q    <= rx_rd_q + RX_AW'(rx_pop);
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            if (lo_wr) div_q[7:0]  <= databus;
            if (hi_wr) div_q[15:8] <= databus;
            div_load_q <= hi_wr;
        end
    end

    assign bus.tx_data  = tx_mem_q[tx_rd_q];
    assign bus.tx_valid = (tx_cnt_q != '0);
    assign bus.divisor  = div_q;
    assign bus.div_load = div_load_q;

`ifdef SPART_BUS_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (rx_cnt_q != '0) | rx_ovf_q | tx_ovf_q;
    end

    assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Self-checking bench for spart_bus_fifo_if: register table, FIFO scoreboards, corner sequences.
module tb_spart_bus_fifo_if;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spart_bus_fifo_if_if bus_if();
    wire  [7:0] databus;
    logic       drv;
    logic [7:0] dout;
    assign databus = drv ? dout : 8'bz;

    spart_bus_fifo_if dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .databus (databus)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic [15:0] exp_div;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_seen[$];
    int tx_idx   = 0;
    int tx_model = 0;
    int dl_cnt   = 0;
    int dl_exp   = 0;

    // Records transmitter handshakes and div_load pulses; the main flow compares them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.tx_valid && bus_if.tx_ready) tx_seen.push_back(bus_if.tx_data);
            if (bus_if.div_load) dl_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end else begin
            $display("ok   %s = %0h", n, act);
        end
    endtask

    task automatic access(input logic rw, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
        @(posedge clk); #1;
        bus_if.iocs = 1'b1; bus_if.iorw = rw; bus_if.ioaddr = a;
        drv = ~rw; dout = d;
        @(negedge clk);
        rd = databus;
        if (!rw) chk("bus_no_contention", databus, d);
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; drv = 1'b0;
        if (!rw && a == 2'd3) dl_exp++;
        @(negedge clk);
        chk("div_load_after_access", bus_if.div_load, (!rw && a == 2'd3));
    endtask

    task automatic tx_write(input logic [7:0] d);
        logic [7:0] rd;
        if (tx_model < 4) begin
            tx_exp.push_back(d);
            tx_model++;
        end
        access(1'b0, 2'd0, d, rd);
    endtask

    task automatic rx_read();
        logic [7:0] rd;
        logic [7:0] e;
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
        access(1'b1, 2'd0, 8'h00, rd);
        chk("rx_data_read", rd, e);
    endtask

    task automatic status_read(input logic [7:0] e);
        logic [7:0] rd;
        access(1'b1, 2'd1, 8'h00, rd);
        chk("status", rd, e);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b1; bus_if.rx_data = d;
        if (rx_exp.size() < 4) rx_exp.push_back(d);
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic tx_check_drained();
        while (tx_idx < tx_seen.size()) begin
            if (tx_exp.size() == 0) chk("tx_unexpected_byte", {24'h0, tx_seen[tx_idx]}, 32'h100);
            else                    chk("tx_data_out", tx_seen[tx_idx], tx_exp.pop_front());
            tx_idx++;
        end
        chk("tx_pending", tx_exp.size(), 0);
        tx_model = 0;
    endtask

    vec_t vt[8];
    logic [7:0] rd;

    initial begin
        vt[0] = '{1'b0, 2'd2, 8'h34, 8'h00, 16'h0134};
        vt[1] = '{1'b0, 2'd3, 8'h12, 8'h00, 16'h1234};
        vt[2] = '{1'b1, 2'd2, 8'h00, 8'h34, 16'h1234};
        vt[3] = '{1'b1, 2'd3, 8'h00, 8'h12, 16'h1234};
        vt[4] = '{1'b1, 2'd1, 8'h00, 8'h42, 16'h1234};
        vt[5] = '{1'b1, 2'd0, 8'h00, 8'h00, 16'h1234};
        vt[6] = '{1'b0, 2'd2, 8'h78, 8'h00, 16'h1278};
        vt[7] = '{1'b1, 2'd2, 8'h00, 8'h78, 16'h1278};

        rst_n = 1'b0;
        bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'd0;
        bus_if.tx_ready = 1'b0; bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'h00;
        drv = 1'b0; dout = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_divisor", bus_if.divisor, 16'h0145);
        chk("reset_tx_valid", bus_if.tx_valid, 0);
        chk("reset_tx_data", bus_if.tx_data, 0);
        chk("reset_div_load", bus_if.div_load, 0);
`ifdef SPART_BUS_IRQ_EN
        chk("reset_irq", bus_if.irq, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        status_read(8'h42);

        // Register table
        for (int i = 0; i < 8; i++) begin
            access(vt[i].rw, vt[i].addr, vt[i].wdata, rd);
            if (vt[i].rw) chk($sformatf("tbl%0d_read", i), rd, vt[i].exp_rd);
            chk($sformatf("tbl%0d_divisor", i), bus_if.divisor, vt[i].exp_div);
        end
        chk("div_load_count_tbl", dl_cnt, dl_exp);

        // TX fill with overflow, then drain
        for (int i = 0; i < 5; i++) tx_write(8'hA1 + 8'(i));
        status_read(8'h08);
        status_read(8'h00);
        @(posedge clk); #1 bus_if.tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("tx_empty_after_4", bus_if.tx_valid, 0);
        @(posedge clk); #1 bus_if.tx_ready = 1'b0;
        tx_check_drained();

        // RX overflow
        for (int i = 0; i < 5; i++) rx_pulse(8'h10 + 8'(i));
`ifdef SPART_BUS_IRQ_EN
        @(negedge clk);
        chk("irq_rx", bus_if.irq, 1);
`endif
        for (int i = 0; i < 5; i++) rx_read();
        status_read(8'h46);
        status_read(8'h42);

        // CPU pop and rx_valid in the same cycle
        rx_pulse(8'h20);
        rx_pulse(8'h21);
        @(posedge clk); #1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = 2'd0;
        bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h22;
        @(negedge clk);
        chk("rx_pop_push_read", databus, rx_exp.pop_front());
        rx_exp.push_back(8'h22);
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; bus_if.rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) rx_read();

        // Empty RX: byte pushed during a DATA read is not yet visible
        @(posedge clk); #1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = 2'd0;
        bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h33;
        @(negedge clk);
        chk("rx_empty_same_cycle", databus, 8'h00);
        rx_exp.push_back(8'h33);
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; bus_if.rx_valid = 1'b0;
        rx_read();
        status_read(8'h42);

        // TX full: CPU push alongside transmitter pop
        for (int i = 0; i < 4; i++) tx_write(8'hB0 + 8'(i));
        @(posedge clk); #1;
        bus_if.tx_ready = 1'b1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'd0;
        drv = 1'b1; dout = 8'h55;
        tx_exp.push_back(8'h55);
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; drv = 1'b0;
        repeat (6) @(negedge clk);
        chk("tx_empty_after_simul", bus_if.tx_valid, 0);
        @(posedge clk); #1 bus_if.tx_ready = 1'b0;
        status_read(8'h42);
        tx_check_drained();

        // Bus float while deselected
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; bus_if.iorw = 1'b1; drv = 1'b1; dout = 8'h5A;
        @(negedge clk);
        chk("bus_float_deselected", databus, 8'h5A);
        @(posedge clk); #1 drv = 1'b0;

        // Back-to-back DIV_HIGH writes
        @(posedge clk); #1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'd3;
        drv = 1'b1; dout = 8'hAB;
        @(posedge clk); #1 dout = 8'hCD;
        @(negedge clk);
        chk("b2b_div_load_1", bus_if.div_load, 1);
        chk("b2b_divisor_1", bus_if.divisor, 16'hAB78);
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; drv = 1'b0;
        @(negedge clk);
        chk("b2b_div_load_2", bus_if.div_load, 1);
        chk("b2b_divisor_2", bus_if.divisor, 16'hCD78);
        @(negedge clk);
        chk("b2b_div_load_end", bus_if.div_load, 0);
        dl_exp += 2;
        chk("div_load_count_b2b", dl_cnt, dl_exp);

        // Reset in the middle of traffic with a div_load pending
        tx_write(8'hC0);
        tx_write(8'hC1);
        rx_pulse(8'h44);
        @(posedge clk); #1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'd3;
        drv = 1'b1; dout = 8'h99;
        @(posedge clk); #1;
        bus_if.iocs = 1'b0; drv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_div_load", bus_if.div_load, 0);
        chk("midrst_tx_valid", bus_if.tx_valid, 0);
        chk("midrst_divisor", bus_if.divisor, 16'h0145);
        chk("midrst_tx_data", bus_if.tx_data, 0);
        tx_exp.delete();
        rx_exp.delete();
        tx_model = 0;
        tx_idx = tx_seen.size();
        @(posedge clk); #1 rst_n = 1'b1;
        status_read(8'h42);
        rx_read();
        access(1'b1, 2'd2, 8'h00, rd);
        chk("midrst_div_low", rd, 8'h45);
        access(1'b1, 2'd3, 8'h00, rd);
        chk("midrst_div_high", rd, 8'h01);
        chk("div_load_count_final", dl_cnt, dl_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spart_bus_fifo_if.md
Name: spart_bus_fifo_if

Overview:
- Clocked, parametrised successor to the SPART's combinational CPU bus interface.
- Sits between the processor's iocs/iorw/ioaddr/databus port and the SPART transmitter, receiver and baud generator.
- Adds depth-configurable TX and RX FIFOs, internally held 16-bit baud divisor registers, and sticky overflow status.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of 2, 2..64.
- RX_DEPTH, 4, RX FIFO entries; power of 2, 2..64.
- DIV_RESET, 16'h0145, divisor value loaded at reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iocs  in  1  chip select; each clk cycle with iocs=1 is one access.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  register select: 00 DATA, 01 STATUS, 10 DIV_LOW, 11 DIV_HIGH.
- databus  inout  8  bidirectional CPU data.
- tx_data  out  8  TX FIFO head.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- divisor  out  16  registered baud divisor.
- div_load  out  1  one-cycle pulse after a DIV_HIGH write.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Both FIFOs empty.
  - Sticky bits 0.
  - divisor=DIV_RESET, div_load=0, tx_valid=0, tx_data=0.
  - databus released (Z).
- databus drive:
  - Driven only when iocs&iorw; combinational from registered state; Z otherwise.
  - Unmapped or write cycles leave the bus at Z.
- DATA read:
  - databus = RX head; head pops at the edge ending the cycle.
  - RX empty: databus=8'h00, no pop, no state change.
- DATA write: databus pushed to TX FIFO at edge.
  - TX full: byte dropped, tx_ovf set.
- STATUS read, databus bits:
  - [0] rda = RX non-empty.
  - [1] tbr = TX not full.
  - [2] rx_ovf.
  - [3] tx_ovf.
  - [7:4] TX free entries, saturated at 15.
  - rx_ovf and tx_ovf clear at the edge ending the STATUS read.
  - A new overflow in that same cycle wins: bit stays 1.
- DIV_LOW write: divisor[7:0] updates at edge; no div_load.
- DIV_HIGH write:
  - divisor[15:8] updates at edge.
  - div_load=1 for exactly the following cycle.
  - Back-to-back DIV_HIGH writes give back-to-back pulses.
- Reads of DIV_LOW/DIV_HIGH return divisor bytes. Divisor is never zeroed by hardware.
- TX side:
  - tx_valid = count!=0; tx_data = head, stable while tx_valid&~tx_ready.
  - Pop on tx_valid&tx_ready.
- RX side:
  - Push on rx_valid.
  - RX full: byte dropped, rx_ovf set; existing contents untouched.
- Simultaneous events:
  - CPU push + transmitter pop same cycle: both occur, count unchanged.
  - Push allowed when full only if a pop occurs in the same cycle.
  - CPU pop + rx_valid same cycle: both occur.
  - RX empty: the pushed byte is not visible until the next cycle.
- Pointers wrap modulo depth; count width = clog2(DEPTH)+1.
- Latency: written byte reaches tx_data 1 cycle after the write edge; received byte is readable 1 cycle after rx_valid.
- Reset mid-operation discards all FIFO contents and pending div_load.

Optional Feature:
- Macro: SPART_BUS_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered, reset 0).
  - irq=1 whenever RX non-empty, rx_ovf, or tx_ovf is set.
  - irq deasserts the cycle after the condition clears.
- Undefined: irq port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-traffic -> divisor=16'h0145, tx_valid=0, STATUS read = 8'h42 (tbr=1, free=4) with defaults.
- TX fill: 5 DATA writes 8'hA1..A5, tx_ready=0 -> first 4 queued, tx_ovf=1, STATUS[1]=0; then tx_ready=1 -> tx_data A1,A2,A3,A4 on consecutive cycles.
- RX overflow: 5 rx_valid pulses 8'h10..14 -> DATA reads return 10,11,12,13, then 8'h00 (empty); STATUS read shows bit2=1, next STATUS read shows bit2=0.
- Divisor: write DIV_LOW=8'h34, then DIV_HIGH=8'h12 -> divisor=16'h1234; div_load pulses once, one cycle after the DIV_HIGH write only.
- Simultaneous: TX full, CPU write 8'h55 in the same cycle as tx_ready=1 -> no overflow, 8'h55 is the last entry out.
- Bus float: iocs=0 or write cycle -> databus is Z; bench drives and checks no contention.
